// File: rtl/imm_pkg.sv
// Shared definitions for the immediate-generation stage.
// Holds the opcode constants, the output format enumeration and the
// bit positions of the instruction fields that hold the immediate.
package imm_pkg;

   typedef enum logic [2:0] {
      FMT_NONE  = 3'd0,
      FMT_I_SX  = 3'd1,
      FMT_I_ZX  = 3'd2,
      FMT_SHAMT = 3'd3,
      FMT_U     = 3'd4,
      FMT_S     = 3'd5,
      FMT_J20   = 3'd6
   } imm_fmt_e;

   localparam logic [4:0] OPC_ISX_A   = 5'h02;
   localparam logic [4:0] OPC_ISX_B   = 5'h0f;
   localparam logic [4:0] OPC_ISX_C   = 5'h14;
   localparam logic [4:0] OPC_IZX_A   = 5'h05;
   localparam logic [4:0] OPC_IZX_B   = 5'h07;
   localparam logic [4:0] OPC_IZX_C   = 5'h09;
   localparam logic [4:0] OPC_SHAMT_A = 5'h0b;
   localparam logic [4:0] OPC_SHAMT_B = 5'h0d;
   localparam logic [4:0] OPC_U       = 5'h0e;
   localparam logic [4:0] OPC_S_A     = 5'h10;
   localparam logic [4:0] OPC_S_B     = 5'h11;
   localparam logic [4:0] OPC_S_C     = 5'h12;
   localparam logic [4:0] OPC_J20     = 5'h13;

   localparam int OPC_MSB   = 4;
   localparam int OPC_LSB   = 0;
   localparam int IMM5_MSB  = 11;
   localparam int IMM5_LSB  = 7;
   localparam int IMM6_MSB  = 25;
   localparam int IMM6_LSB  = 20;
   localparam int IMM7_MSB  = 31;
   localparam int IMM7_LSB  = 25;
   localparam int IMM12_MSB = 31;
   localparam int IMM12_LSB = 20;
   localparam int IMM20_MSB = 31;
   localparam int IMM20_LSB = 12;

endpackage

// File: rtl/imm_gen_stage_if.sv
// Handshake bundle of the immediate-generation stage.
//   upstream   : in_valid, in_ready, in_ins, in_tag
//   downstream : out_valid, out_ready, out_imm, out_fmt, out_tag
// master = the side that offers instructions and consumes results,
// slave  = the stage itself.
interface imm_gen_stage_if #(
   parameter int XLEN = 32,
   parameter int TAGW = 4
);
   import imm_pkg::*;

   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_ins;
   logic [TAGW-1:0] in_tag;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_imm;
   imm_fmt_e        out_fmt;
   logic [TAGW-1:0] out_tag;

   modport master (
      output in_valid, in_ins, in_tag, out_ready,
      input  in_ready, out_valid, out_imm, out_fmt, out_tag
   );

   modport slave (
      input  in_valid, in_ins, in_tag, out_ready,
      output in_ready, out_valid, out_imm, out_fmt, out_tag
   );
endinterface

// File: rtl/imm_extract.sv
// Combinational immediate decode and extension.
//   ins_i : 32-bit instruction word
//   imm_o : immediate extended to XLEN bits (0 for unrecognised opcodes)
//   fmt_o : format code of the decoded immediate
module imm_extract
   import imm_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     ins_i,
   output logic [XLEN-1:0] imm_o,
   output imm_fmt_e        fmt_o
);

   logic [4:0]  opc;
   logic [11:0] imm12;
   logic [11:0] imm_s;
   logic [5:0]  imm6;
   logic [19:0] imm20;

   assign opc   = ins_i[OPC_MSB:OPC_LSB];
   assign imm12 = ins_i[IMM12_MSB:IMM12_LSB];
   assign imm_s = {ins_i[IMM7_MSB:IMM7_LSB], ins_i[IMM5_MSB:IMM5_LSB]};
   assign imm6  = ins_i[IMM6_MSB:IMM6_LSB];
   assign imm20 = ins_i[IMM20_MSB:IMM20_LSB];

   always_comb begin
      imm_o = '0;
      fmt_o = FMT_NONE;
      case (opc)
         OPC_ISX_A, OPC_ISX_B, OPC_ISX_C: begin
            imm_o = XLEN'($signed(imm12));
            fmt_o = FMT_I_SX;
         end
         OPC_IZX_A, OPC_IZX_B, OPC_IZX_C: begin
            imm_o = XLEN'(imm12);
            fmt_o = FMT_I_ZX;
         end
         OPC_SHAMT_A, OPC_SHAMT_B: begin
            imm_o = XLEN'(imm6);
            // a 32-bit datapath can only shift by 0..31
            if (XLEN == 32) imm_o[5] = 1'b0;
            fmt_o = FMT_SHAMT;
         end
         OPC_U: begin
            imm_o = XLEN'($signed({imm20, 12'h000}));
            fmt_o = FMT_U;
         end
         OPC_S_A, OPC_S_B, OPC_S_C: begin
            imm_o = XLEN'($signed(imm_s));
            fmt_o = FMT_S;
         end
         OPC_J20: begin
            imm_o = XLEN'($signed(imm20));
            fmt_o = FMT_J20;
         end
         default: begin
            imm_o = '0;
            fmt_o = FMT_NONE;
         end
      endcase
   end

endmodule

// File: rtl/imm_gen_stage.sv
// Immediate-generation pipeline stage: decodes the immediate of each
// accepted instruction and presents it downstream through an output
// register backed by a one-entry skid register.
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : drop everything held plus any instruction accepted now
//   bus        : upstream/downstream valid-ready handshake (slave side)
//   stall_cnt  : saturating count of cycles with out_valid & !out_ready
module imm_gen_stage
   import imm_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int TAGW = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   imm_gen_stage_if.slave    bus,
   output logic [15:0]       stall_cnt
);

   localparam int DW = XLEN + 3 + TAGW;

   logic [XLEN-1:0] ext_imm;
   imm_fmt_e        ext_fmt;
   logic [DW-1:0]   new_data;

   logic          out_valid_q, out_valid_d;
   logic [DW-1:0] out_q, out_d;
   logic          skid_valid_q, skid_valid_d;
   logic [DW-1:0] skid_q, skid_d;
   logic [15:0]   stall_q, stall_d;
   logic          accept, drain;

   imm_extract #(.XLEN(XLEN)) u_extract (
      .ins_i (bus.in_ins),
      .imm_o (ext_imm),
      .fmt_o (ext_fmt)
   );

   assign new_data = {ext_imm, ext_fmt, bus.in_tag};
   assign accept   = bus.in_valid & ~skid_valid_q;
   assign drain    = out_valid_q & bus.out_ready;

   always_comb begin
      out_valid_d  = out_valid_q;
      out_d        = out_q;
      skid_valid_d = skid_valid_q;
      skid_d       = skid_q;
      if (flush) begin
         out_valid_d  = 1'b0;
         skid_valid_d = 1'b0;
      end else if (!out_valid_q || drain) begin
         // skid is only ever occupied while the output is full, and while
         // it is occupied nothing is accepted, so it refills the output first
         if (skid_valid_q) begin
            out_d        = skid_q;
            out_valid_d  = 1'b1;
            skid_valid_d = 1'b0;
         end else begin
            out_valid_d = accept;
            if (accept) out_d = new_data;
         end
      end else if (accept) begin
         skid_d       = new_data;
         skid_valid_d = 1'b1;
      end
   end

   always_comb begin
      stall_d = stall_q;
      if (out_valid_q && !bus.out_ready && stall_q != 16'hFFFF)
         stall_d = stall_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q  <= 1'b0;
         out_q        <= '0;
         skid_valid_q <= 1'b0;
         skid_q       <= '0;
         stall_q      <= '0;
      end else begin
         out_valid_q  <= out_valid_d;
         out_q        <= out_d;
         skid_valid_q <= skid_valid_d;
         skid_q       <= skid_d;
         stall_q      <= stall_d;
      end
   end

   assign bus.in_ready  = ~skid_valid_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_imm   = out_q[DW-1 -: XLEN];
   assign bus.out_fmt   = imm_fmt_e'(out_q[TAGW +: 3]);
   assign bus.out_tag   = out_q[TAGW-1:0];
   assign stall_cnt     = stall_q;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Bench for imm_gen_stage: a 32-bit and a 64-bit instance share the same
// stimulus and are checked against an arithmetic reference model.
module tb_imm_gen_stage;
   import imm_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic [15:0] stall32, stall64;
   int          tests = 0;
   int          fails = 0;

   always #5 clk = ~clk;

   imm_gen_stage_if #(.XLEN(32), .TAGW(4)) b32 ();
   imm_gen_stage_if #(.XLEN(64), .TAGW(4)) b64 ();

   assign b64.in_valid  = b32.in_valid;
   assign b64.in_ins    = b32.in_ins;
   assign b64.in_tag    = b32.in_tag;
   assign b64.out_ready = b32.out_ready;

   imm_gen_stage #(.XLEN(32), .TAGW(4)) dut32 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .bus(b32.slave), .stall_cnt(stall32));
   imm_gen_stage #(.XLEN(64), .TAGW(4)) dut64 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .bus(b64.slave), .stall_cnt(stall64));

   typedef struct {
      logic [31:0] imm32;
      logic [63:0] imm64;
      imm_fmt_e    fmt;
      logic [3:0]  tag;
   } exp_t;

   exp_t mq[$];
   int   m_stall = 0;

   // immediate value computed with plain integer arithmetic on the word
   function automatic void ref_decode(input logic [31:0] ins, input bit x64,
                                      output logic [63:0] imm, output imm_fmt_e fmt);
      longint u, v, opc;
      u   = {32'd0, ins};
      opc = u % 32;
      v   = 0;
      fmt = FMT_NONE;
      case (opc)
         2, 15, 20: begin
            v = u / 1048576; if (v >= 2048) v -= 4096; fmt = FMT_I_SX;
         end
         5, 7, 9: begin v = u / 1048576; fmt = FMT_I_ZX; end
         11, 13: begin
            v = (u / 1048576) % 64; if (!x64) v = v % 32; fmt = FMT_SHAMT;
         end
         14: begin
            v = (u / 4096) * 4096;
            if (v >= 64'sd2147483648) v -= 64'sd4294967296;
            fmt = FMT_U;
         end
         16, 17, 18: begin
            v = (u / 33554432) * 32 + (u / 128) % 32;
            if (v >= 2048) v -= 4096;
            fmt = FMT_S;
         end
         19: begin
            v = u / 4096; if (v >= 524288) v -= 1048576; fmt = FMT_J20;
         end
         default: begin v = 0; fmt = FMT_NONE; end
      endcase
      imm = v;
   endfunction

   function automatic exp_t make_exp(input logic [31:0] ins, input logic [3:0] tag);
      exp_t        e;
      logic [63:0] i32, i64;
      imm_fmt_e    f;
      ref_decode(ins, 1'b0, i32, f);
      ref_decode(ins, 1'b1, i64, f);
      e.imm32 = i32[31:0];
      e.imm64 = i64;
      e.fmt   = f;
      e.tag   = tag;
      return e;
   endfunction

   // stage modelled as an ordered list of at most two results
   always @(posedge clk) begin
      if (!rst_n) begin
         mq.delete();
         m_stall = 0;
      end else begin
         bit acc;
         if (mq.size() > 0 && !b32.out_ready && m_stall < 65535) m_stall++;
         acc = b32.in_valid && (mq.size() < 2);
         if (flush) mq.delete();
         else begin
            if (mq.size() > 0 && b32.out_ready) void'(mq.pop_front());
            if (acc) mq.push_back(make_exp(b32.in_ins, b32.in_tag));
         end
      end
   end

   task automatic drive(input bit v, input logic [31:0] ins, input logic [3:0] tag,
                        input bit ordy, input bit fl);
      b32.in_valid  = v;
      b32.in_ins    = ins;
      b32.in_tag    = tag;
      b32.out_ready = ordy;
      flush         = fl;
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      drive(0, 32'h0, 4'h0, 0, 0);
      rst_n = 1'b0;
      #12;
      tests++; if (b32.out_valid !== 1'b0 || b64.out_valid !== 1'b0) begin
         fails++; $display("FAIL reset_out_valid got=%b/%b exp=0", b32.out_valid, b64.out_valid); end
      tests++; if (b32.out_imm !== 32'h0 || b64.out_imm !== 64'h0) begin
         fails++; $display("FAIL reset_out_imm got=%h/%h exp=0", b32.out_imm, b64.out_imm); end
      tests++; if (b32.out_fmt !== FMT_NONE || b64.out_fmt !== FMT_NONE) begin
         fails++; $display("FAIL reset_out_fmt got=%0d/%0d exp=0", b32.out_fmt, b64.out_fmt); end
      tests++; if (b32.out_tag !== 4'h0 || stall32 !== 16'h0 || stall64 !== 16'h0) begin
         fails++; $display("FAIL reset_tag_stall got=%h/%h/%h exp=0", b32.out_tag, stall32, stall64); end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      tests++; if (b32.in_ready !== 1'b1 || b64.in_ready !== 1'b1 || b32.out_valid !== 1'b0) begin
         fails++; $display("FAIL reset_release got in_ready=%b out_valid=%b exp 1/0", b32.in_ready, b32.out_valid); end
   endtask

   task automatic test_vectors();
      drive(1, 32'hFFF00002, 4'h7, 1, 0);
      tick();
      tests++; if (b32.out_valid !== 1'b1 || b32.out_imm !== 32'hFFFFFFFF || b32.out_fmt !== FMT_I_SX || b32.out_tag !== 4'h7) begin
         fails++; $display("FAIL vec_isx got v=%b imm=%h fmt=%0d tag=%h exp 1/ffffffff/1/7", b32.out_valid, b32.out_imm, b32.out_fmt, b32.out_tag); end
      drive(1, 32'h8000000E, 4'h8, 1, 0);
      tick();
      tests++; if (b64.out_imm !== 64'hFFFFFFFF80000000 || b64.out_fmt !== FMT_U) begin
         fails++; $display("FAIL vec_u64 got imm=%h fmt=%0d exp ffffffff80000000/4", b64.out_imm, b64.out_fmt); end
      tests++; if (b32.out_imm !== 32'h80000000) begin
         fails++; $display("FAIL vec_u32 got imm=%h exp 80000000", b32.out_imm); end
      drive(1, 32'h02A00005, 4'h9, 1, 0);
      tick();
      tests++; if (b64.out_imm !== 64'h2A || b64.out_fmt !== FMT_I_ZX || b32.out_imm !== 32'h2A) begin
         fails++; $display("FAIL vec_izx got imm=%h/%h fmt=%0d exp 2a/2a/2", b32.out_imm, b64.out_imm, b64.out_fmt); end
      drive(1, 32'h03F0000B, 4'hA, 1, 0);
      tick();
      tests++; if (b32.out_imm !== 32'h1F || b64.out_imm !== 64'h3F || b32.out_fmt !== FMT_SHAMT) begin
         fails++; $display("FAIL vec_shamt got imm=%h/%h fmt=%0d exp 1f/3f/3", b32.out_imm, b64.out_imm, b32.out_fmt); end
      drive(0, 32'h0, 4'h0, 1, 0);
      tick();
      tests++; if (b32.out_valid !== 1'b0) begin
         fails++; $display("FAIL vec_drain got out_valid=%b exp 0", b32.out_valid); end
   endtask

   task automatic test_back_to_back();
      exp_t e1;
      logic [31:0] ins1;
      ins1 = $urandom;
      e1 = make_exp(ins1, 4'h1);
      drive(1, ins1, 4'h1, 0, 0);
      tick();
      tests++; if (b32.out_tag !== 4'h1 || b32.in_ready !== 1'b1) begin
         fails++; $display("FAIL b2b_first got tag=%h in_ready=%b exp 1/1", b32.out_tag, b32.in_ready); end
      drive(1, $urandom, 4'h2, 0, 0);
      tick();
      tests++; if (b32.out_tag !== 4'h1 || b32.in_ready !== 1'b0) begin
         fails++; $display("FAIL b2b_skid got tag=%h in_ready=%b exp 1/0", b32.out_tag, b32.in_ready); end
      drive(1, $urandom, 4'h3, 0, 0);
      tick();
      tests++; if (b32.out_tag !== 4'h1 || b32.in_ready !== 1'b0 || b32.out_valid !== 1'b1 || b32.out_imm !== e1.imm32 || b64.out_imm !== e1.imm64) begin
         fails++; $display("FAIL b2b_hold got tag=%h in_ready=%b imm=%h exp 1/0/%h", b32.out_tag, b32.in_ready, b32.out_imm, e1.imm32); end
      b32.out_ready = 1'b1;
      tick();
      tests++; if (b32.out_tag !== 4'h2 || b32.out_valid !== 1'b1) begin
         fails++; $display("FAIL b2b_second got tag=%h exp 2", b32.out_tag); end
      tick();
      tests++; if (b32.out_tag !== 4'h3 || b32.out_valid !== 1'b1) begin
         fails++; $display("FAIL b2b_third got tag=%h exp 3", b32.out_tag); end
      drive(0, 32'h0, 4'h0, 1, 0);
      tick();
      tests++; if (b32.out_valid !== 1'b0) begin
         fails++; $display("FAIL b2b_empty got out_valid=%b exp 0", b32.out_valid); end
   endtask

   task automatic test_flush();
      drive(1, $urandom, 4'h4, 0, 0);
      tick();
      drive(1, $urandom, 4'h5, 0, 0);
      tick();
      drive(1, $urandom, 4'h6, 0, 1);
      tick();
      tests++; if (b32.out_valid !== 1'b0 || b32.in_ready !== 1'b1 || b64.out_valid !== 1'b0) begin
         fails++; $display("FAIL flush_full got out_valid=%b in_ready=%b exp 0/1", b32.out_valid, b32.in_ready); end
      drive(0, 32'h0, 4'h0, 1, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         tests++; if (b32.out_valid !== 1'b0) begin
            fails++; $display("FAIL flush_ghost got out_valid=%b tag=%h exp 0", b32.out_valid, b32.out_tag); end
      end
      drive(1, $urandom, 4'h9, 0, 0);
      tick();
      drive(1, $urandom, 4'hA, 0, 1);
      tick();
      tests++; if (b32.out_valid !== 1'b0 || b32.in_ready !== 1'b1) begin
         fails++; $display("FAIL flush_accept got out_valid=%b in_ready=%b exp 0/1", b32.out_valid, b32.in_ready); end
      tests++; if (stall32 !== 16'(m_stall)) begin
         fails++; $display("FAIL flush_stall got %0d exp %0d", stall32, m_stall); end
      drive(0, 32'h0, 4'h0, 1, 0);
      tick();
      tests++; if (b32.out_valid !== 1'b0) begin
         fails++; $display("FAIL flush_drop got out_valid=%b tag=%h exp 0", b32.out_valid, b32.out_tag); end
   endtask

   task automatic test_random();
      for (int c = 0; c < 600; c++) begin
         logic [31:0] ins;
         ins = $urandom;
         drive($urandom_range(0, 9) < 7, ins, 4'($urandom), $urandom_range(0, 9) < 6,
               $urandom_range(0, 19) == 0);
         tick();
         tests++; if (b32.out_valid !== (mq.size() > 0) || b64.out_valid !== (mq.size() > 0)) begin
            fails++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", c, b32.out_valid, mq.size() > 0); end
         tests++; if (b32.in_ready !== (mq.size() < 2)) begin
            fails++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", c, b32.in_ready, mq.size() < 2); end
         tests++; if (stall32 !== 16'(m_stall) || stall64 !== 16'(m_stall)) begin
            fails++; $display("FAIL rnd_stall cyc=%0d got=%0d exp=%0d", c, stall32, m_stall); end
         if (mq.size() > 0) begin
            tests++; if (b32.out_imm !== mq[0].imm32 || b64.out_imm !== mq[0].imm64) begin
               fails++; $display("FAIL rnd_imm cyc=%0d got=%h/%h exp=%h/%h", c, b32.out_imm, b64.out_imm, mq[0].imm32, mq[0].imm64); end
            tests++; if (b32.out_fmt !== mq[0].fmt || b64.out_fmt !== mq[0].fmt || b32.out_tag !== mq[0].tag) begin
               fails++; $display("FAIL rnd_fmt_tag cyc=%0d got=%0d/%h exp=%0d/%h", c, b32.out_fmt, b32.out_tag, mq[0].fmt, mq[0].tag); end
         end
      end
      drive(0, 32'h0, 4'h0, 1, 0);
      tick();
      tick();
   endtask

   task automatic test_async_reset();
      drive(1, 32'hFFF00002, 4'h5, 0, 0);
      tick();
      drive(0, 32'h0, 4'h0, 0, 0);
      tests++; if (b32.out_valid !== 1'b1) begin
         fails++; $display("FAIL async_pre got out_valid=%b exp 1", b32.out_valid); end
      #2 rst_n = 1'b0;
      #1;
      tests++; if (b32.out_valid !== 1'b0 || b64.out_valid !== 1'b0 || b32.out_imm !== 32'h0 || b32.out_tag !== 4'h0) begin
         fails++; $display("FAIL async_now got v=%b imm=%h tag=%h exp 0/0/0", b32.out_valid, b32.out_imm, b32.out_tag); end
      @(negedge clk);
      rst_n = 1'b1;
      tests++; if (b32.out_valid !== 1'b0 || b32.in_ready !== 1'b1) begin
         fails++; $display("FAIL async_release got v=%b in_ready=%b exp 0/1", b32.out_valid, b32.in_ready); end
      drive(1, 32'h0000007F, 4'h6, 1, 0);
      tick();
      tests++; if (b32.out_valid !== 1'b1 || b32.out_fmt !== FMT_NONE || b32.out_imm !== 32'h0 || b64.out_imm !== 64'h0 || b32.out_tag !== 4'h6) begin
         fails++; $display("FAIL async_none got v=%b fmt=%0d imm=%h tag=%h exp 1/0/0/6", b32.out_valid, b32.out_fmt, b32.out_imm, b32.out_tag); end
      drive(0, 32'h0, 4'h0, 1, 0);
      tick();
   endtask

   task automatic test_stall();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tests++; if (stall32 !== 16'h0) begin
         fails++; $display("FAIL stall_clear got %0d exp 0", stall32); end
      drive(1, $urandom, 4'h1, 0, 0);
      tick();
      drive(0, 32'h0, 4'h0, 0, 0);
      repeat (9) tick();
      tests++; if (stall32 !== 16'd9 || stall64 !== 16'd9) begin
         fails++; $display("FAIL stall_count got %0d/%0d exp 9", stall32, stall64); end
      repeat (70000) tick();
      tests++; if (stall32 !== 16'hFFFF || stall64 !== 16'hFFFF) begin
         fails++; $display("FAIL stall_sat got %h/%h exp ffff", stall32, stall64); end
      repeat (3) tick();
      drive(0, 32'h0, 4'h0, 0, 1);
      tick();
      drive(0, 32'h0, 4'h0, 0, 0);
      tests++; if (stall32 !== 16'hFFFF || b32.out_valid !== 1'b0) begin
         fails++; $display("FAIL stall_hold got %h v=%b exp ffff/0", stall32, b32.out_valid); end
      rst_n = 1'b0;
      #1;
      tests++; if (stall32 !== 16'h0 || stall64 !== 16'h0) begin
         fails++; $display("FAIL stall_reset got %h/%h exp 0", stall32, stall64); end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      test_reset();
      test_vectors();
      test_back_to_back();
      test_flush();
      test_random();
      test_async_reset();
      test_stall();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/imm_gen_stage.md
IMM_GEN_STAGE -- requirements
Module: imm_gen_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width of the produced immediate; legal values 32 and 64.
REQ-002 Parameter TAGW, default 4, width of the sideband tag carried alongside each instruction.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  upstream (IF/ID) offers an instruction.
REQ-006 in_ready  output  1  stage can accept an instruction this cycle.
REQ-007 in_ins  input  32  instruction word.
REQ-008 in_tag  input  TAGW  sideband tag (e.g. PC slot), passed through unchanged.
REQ-009 flush  input  1  discard every held and incoming instruction.
REQ-010 out_valid  output  1  out_imm/out_fmt/out_tag hold a valid result.
REQ-011 out_ready  input  1  downstream (ID/EX) accepts the result.
REQ-012 out_imm  output  XLEN  extended immediate.
REQ-013 out_fmt  output  3  immediate format code: NONE, I_SX, I_ZX, SHAMT, U, S, J20.
REQ-014 out_tag  output  TAGW  tag of the instruction in out_imm.
REQ-015 stall_cnt  output  16  saturating count of cycles with out_valid=1 and out_ready=0.

Function
REQ-016 Opcode = in_ins[4:0]; fields imm5=[11:7], imm6=[25:20], imm7=[31:25], imm12=[31:20], imm20=[31:12].
REQ-017 Opcodes 0x02, 0x0f, 0x14 -> I_SX: imm12 sign-extended to XLEN.
REQ-018 Opcodes 0x05, 0x07, 0x09 -> I_ZX: imm12 zero-extended to XLEN.
REQ-019 Opcodes 0x0b, 0x0d -> SHAMT: imm6 zero-extended; when XLEN=32, bit 5 of imm6 is forced to 0.
REQ-020 Opcode 0x0e -> U: {imm20, 12'h000}, sign-extended from bit 31 when XLEN=64.
REQ-021 Opcodes 0x10, 0x11, 0x12 -> S: {imm7, imm5} sign-extended to XLEN.
REQ-022 Opcode 0x13 -> J20: imm20 sign-extended to XLEN.
REQ-023 All other opcodes -> NONE with out_imm = 0; the instruction still passes through the handshake.
REQ-024 Handshake: transfer on in_valid & in_ready (input) and out_valid & out_ready (output); no combinational path from in_valid to out_valid.
REQ-025 Storage: one output register plus one skid register; in_ready = skid register empty (registered, no dependence on out_ready).
REQ-026 Latency: accepted instruction appears on outputs the next cycle when the output register is empty or draining; throughput 1 per cycle under continuous out_ready.
REQ-027 Output full and out_ready=0 on accept: incoming result goes to skid; in_ready drops next cycle.
REQ-028 Output drains with skid occupied: skid moves to output next cycle; ordering strictly preserved.
REQ-029 Simultaneous drain and accept with skid empty: new result loads output register directly.
REQ-030 Outputs held stable while out_valid=1 and out_ready=0.
REQ-031 flush: next cycle out_valid=0 and skid empty; an input accepted in the flush cycle is dropped; flush dominates all other events.
REQ-032 stall_cnt increments per stall cycle, saturates at 0xFFFF, is unaffected by flush, and clears only on reset.

Reset
REQ-033 rst_n low: out_valid=0, skid empty, in_ready=1 after release, out_imm=0, out_fmt=NONE, out_tag=0, stall_cnt=0, asynchronously.
REQ-034 Reset mid-transfer discards all held instructions; no partial result ever appears after release.

Structure
REQ-035 Shared package imm_pkg holds opcode constants, the out_fmt enumeration, and the field-position constants.
REQ-036 Combinational decode/extend is a sub-module imm_extract (in_ins -> imm, fmt, parametrised by XLEN); imm_gen_stage adds buffering, flush, and counter.

Verification
REQ-037 XLEN=32, in_ins=0xFFF00002, out_ready=1 -> next cycle out_imm=0xFFFFFFFF, out_fmt=I_SX.
REQ-038 XLEN=64, in_ins=0x8000000E -> out_imm=0xFFFFFFFF80000000, out_fmt=U; in_ins=0x02A00005 -> 0x2A, I_ZX.
REQ-039 out_ready=0, three back-to-back instructions with tags 1,2,3 -> tags 1 and 2 held, in_ready=0, tag 3 waits; out_ready=1 -> tags 1,2,3 emerge in order on consecutive cycles.
REQ-040 Output and skid full, flush asserted with in_valid=1 -> next cycle out_valid=0, in_ready=1, and none of those three tags ever appear.
REQ-041 out_ready held 0 for 70000 cycles -> stall_cnt=0xFFFF and stays there; rst_n pulse -> 0.
REQ-042 rst_n asserted asynchronously between clock edges with out_valid=1 -> out_valid=0 immediately; in_ins=0x0000007F after release -> out_fmt=NONE, out_imm=0.
